// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI response controller: controller state
// encoding, default command codes, fixed response codes and the status-byte
// packing helper.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWaitCost,
        StLoad,
        StShift
    } state_e;

    // Default command bytes understood by the controller.
    localparam logic [7:0] CMD_COST_DEF   = 8'h01;
    localparam logic [7:0] CMD_DIGIT_DEF  = 8'h02;
    localparam logic [7:0] CMD_STATUS_DEF = 8'h03;

    // Fixed response codes.
    localparam logic [7:0] RESP_TIMEOUT  = 8'hFE;  // cost engine did not answer
    localparam logic [7:0] RESP_NO_DIGIT = 8'hFF;  // no fresh digit available

    // Status byte layout: {5'b0, dig_valid, waiting_for_cost, cost_seen}.
    function automatic logic [7:0] status_byte(input logic dig_valid,
                                               input logic waiting,
                                               input logic cost_seen);
        return {5'b00000, dig_valid, waiting, cost_seen};
    endfunction

endpackage

// File: rtl/spi_response_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_response_ctrl_if
// Bundles the SPI-side handshake (slave select, SCK edge strobe, received
// command, transmit load/data/shift) together with the network and cost engine
// handshakes used by spi_response_ctrl.
//   slave  modport: the controller's view (inputs from SPI front end / engines).
//   master modport: the environment's view (drives stimulus, observes outputs).
// -----------------------------------------------------------------------------
interface spi_response_ctrl_if;

    logic       ss_n;
    logic       sck_edge;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       network_done;
    logic [3:0] detected_digit;
    logic       cost_ready;
    logic [7:0] cost_output;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       tx_shift;
    logic       cost_req;
    logic       busy;

    modport slave (
        input  ss_n,
        input  sck_edge,
        input  rx_valid,
        input  rx_byte,
        input  network_done,
        input  detected_digit,
        input  cost_ready,
        input  cost_output,
        output tx_load,
        output tx_data,
        output tx_shift,
        output cost_req,
        output busy
    );

    modport master (
        output ss_n,
        output sck_edge,
        output rx_valid,
        output rx_byte,
        output network_done,
        output detected_digit,
        output cost_ready,
        output cost_output,
        input  tx_load,
        input  tx_data,
        input  tx_shift,
        input  cost_req,
        input  busy
    );

endinterface

// File: rtl/spi_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// 3-bit bit counter for the shift phase.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   clr   : synchronous clear (wins over en)
//   en    : count enable, one increment per cycle
//   tc    : terminal count, high while the count is 7
// -----------------------------------------------------------------------------
module spi_bit_counter (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 3'd0;
        end else if (en) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 3'd7);

endmodule

// File: rtl/spi_response_ctrl.sv
// -----------------------------------------------------------------------------
// spi_response_ctrl
// Answers SPI command bytes with a one-byte response: the cost value (fetched
// from the cost engine with a timeout), the last detected digit, or a status
// byte. The response is handed to an external shift register via tx_load /
// tx_data and then shifted out under control of tx_shift.
//   clk, n_rst : system clock (rising edge), asynchronous active-low reset
//   bus        : spi_response_ctrl_if.slave
//                in : ss_n, sck_edge, rx_valid, rx_byte, network_done,
//                     detected_digit, cost_ready, cost_output
//                out: tx_load, tx_data, tx_shift, cost_req, busy
// -----------------------------------------------------------------------------
module spi_response_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned COST_TIMEOUT = 255,
    parameter logic [7:0]  CMD_COST     = CMD_COST_DEF,
    parameter logic [7:0]  CMD_DIGIT    = CMD_DIGIT_DEF,
    parameter logic [7:0]  CMD_STATUS   = CMD_STATUS_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    spi_response_ctrl_if.slave bus
);

    // Wait counter runs 0 .. COST_TIMEOUT-1, so LOAD follows exactly
    // COST_TIMEOUT cycles after WAIT_COST is entered.
    localparam int unsigned    TW        = (COST_TIMEOUT < 2) ? 1 : $clog2(COST_TIMEOUT + 1);
    localparam logic [TW-1:0]  WAIT_LAST = TW'(COST_TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]     cost_resp_q, cost_resp_d;
    logic           dig_valid_q, dig_valid_d;
    logic [3:0]     digit_q, digit_d;
    logic           cost_seen_q, cost_seen_d;
    logic [7:0]     tx_data_q, tx_data_d;

    logic [7:0]     response;
    logic           tx_load, tx_shift, cost_req;
    logic           bit_clr, bit_en, bit_tc;
    logic           read_digit, read_status;

    spi_bit_counter u_bit_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (bit_clr),
        .en    (bit_en),
        .tc    (bit_tc)
    );

    // Next state and per-state strobes. Slave select high in any active state
    // abandons the transaction; a LOAD in progress still issues its tx_load.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wait_cnt_d  = wait_cnt_q;
        cost_resp_d = cost_resp_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        cost_req    = 1'b0;
        bit_clr     = 1'b1;
        bit_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (bus.rx_valid && !bus.ss_n) begin
                    cmd_d   = bus.rx_byte;
                    state_d = StDecode;
                end
            end

            StDecode: begin
                if (bus.ss_n) begin
                    state_d = StIdle;
                end else if (cmd_q == CMD_COST) begin
                    cost_req   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StWaitCost;
                end else if (cmd_q == CMD_DIGIT || cmd_q == CMD_STATUS) begin
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end

            StWaitCost: begin
                if (bus.ss_n) begin
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else if (bus.cost_ready) begin
                    cost_resp_d = bus.cost_output;
                    wait_cnt_d  = '0;
                    state_d     = StLoad;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    cost_resp_d = RESP_TIMEOUT;
                    wait_cnt_d  = '0;
                    state_d     = StLoad;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end

            StLoad: begin
                tx_load = 1'b1;
                state_d = bus.ss_n ? StIdle : StShift;
            end

            StShift: begin
                tx_shift = bus.sck_edge;
                bit_clr  = bus.ss_n;
                bit_en   = bus.sck_edge;
                if (bus.ss_n || (bus.sck_edge && bit_tc)) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response selection; only meaningful while in LOAD.
    always_comb begin
        if (cmd_q == CMD_COST) begin
            response = cost_resp_q;
        end else if (cmd_q == CMD_DIGIT) begin
            response = dig_valid_q ? {4'h0, digit_q} : RESP_NO_DIGIT;
        end else begin
            response = status_byte(dig_valid_q, state_q == StWaitCost, cost_seen_q);
        end
    end

    assign read_digit  = (state_q == StLoad) && (cmd_q == CMD_DIGIT);
    assign read_status = (state_q == StLoad) && (cmd_q == CMD_STATUS);

    // Digit buffer, cost_seen flag and held tx_data. A new digit arriving in
    // the same cycle it is read keeps dig_valid set.
    always_comb begin
        dig_valid_d = dig_valid_q;
        digit_d     = digit_q;
        cost_seen_d = cost_seen_q;
        tx_data_d   = tx_data_q;

        if (bus.network_done) begin
            dig_valid_d = 1'b1;
            digit_d     = bus.detected_digit;
        end else if (read_digit) begin
            dig_valid_d = 1'b0;
        end

        if (bus.cost_ready) begin
            cost_seen_d = 1'b1;
        end else if (read_status) begin
            cost_seen_d = 1'b0;
        end

        if (state_q == StLoad) begin
            tx_data_d = response;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            cmd_q       <= 8'h00;
            wait_cnt_q  <= '0;
            cost_resp_q <= 8'h00;
            dig_valid_q <= 1'b0;
            digit_q     <= 4'h0;
            cost_seen_q <= 1'b0;
            tx_data_q   <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wait_cnt_q  <= wait_cnt_d;
            cost_resp_q <= cost_resp_d;
            dig_valid_q <= dig_valid_d;
            digit_q     <= digit_d;
            cost_seen_q <= cost_seen_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // tx_data presents the response during LOAD itself, then holds it.
    assign bus.tx_data  = (state_q == StLoad) ? response : tx_data_q;
    assign bus.tx_load  = tx_load;
    assign bus.tx_shift = tx_shift;
    assign bus.cost_req = cost_req;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_response_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_response_ctrl
// Scoreboard bench: the expected response byte is queued when a command is
// issued and compared when the controller pulses tx_load.
// -----------------------------------------------------------------------------
module tb_spi_response_ctrl;

    localparam int unsigned TIMEOUT = 255;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    spi_response_ctrl_if bus ();

    spi_response_ctrl #(
        .COST_TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp     = 0;
    int         n_err     = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;
    int         load_cnt  = 0;
    int         shift_cnt = 0;
    int         creq_cnt  = 0;
    int         cyc       = 0;
    int         load_cyc  = 0;
    int         creq_cyc  = 0;

    // Reference state of the digit buffer and cost_seen flag.
    logic       m_dv    = 1'b0;
    logic [3:0] m_digit = 4'h0;
    logic       m_cs    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.tx_shift) shift_cnt++;
        if (bus.cost_req) begin
            creq_cnt++;
            creq_cyc = cyc;
        end
        if (bus.tx_load) begin
            load_cnt++;
            load_cyc = cyc;
            if (sb.size() == 0) begin
                check_eq("spurious_load", sb.size(), 1);
            end else begin
                sb_exp = sb.pop_front();
                check_eq("tx_data", bus.tx_data, sb_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bus.ss_n     = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_load(input int l0);
        int n = 0;
        while (load_cnt == l0 && n < 400) begin
            tick();
            n++;
        end
        check_eq("load_count", load_cnt - l0, 1);
    endtask

    task automatic do_shift(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sck_edge = 1'b1;
            tick();
            bus.sck_edge = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_done(input logic [3:0] d);
        bus.network_done   = 1'b1;
        bus.detected_digit = d;
        tick();
        bus.network_done = 1'b0;
        m_dv    = 1'b1;
        m_digit = d;
    endtask

    task automatic pulse_cost(input logic [7:0] v);
        bus.cost_ready  = 1'b1;
        bus.cost_output = v;
        tick();
        bus.cost_ready = 1'b0;
        m_cs = 1'b1;
    endtask

    task automatic txn(input logic [7:0] cmd, input logic [7:0] expv);
        int l0 = load_cnt;
        int s0 = shift_cnt;
        sb.push_back(expv);
        send_cmd(cmd);
        wait_load(l0);
        do_shift(8);
        check_eq("shift_pulses", shift_cnt - s0, 8);
        check_eq("busy_after", bus.busy, 0);
    endtask

    task automatic read_digit();
        logic [7:0] e = m_dv ? {4'h0, m_digit} : 8'hFF;
        m_dv = 1'b0;
        txn(8'h02, e);
    endtask

    task automatic read_status();
        logic [7:0] e = {5'b00000, m_dv, 1'b0, m_cs};
        m_cs = 1'b0;
        txn(8'h03, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, c0, s0;
        bus.ss_n           = 1'b1;
        bus.sck_edge       = 1'b0;
        bus.rx_valid       = 1'b0;
        bus.rx_byte        = 8'h00;
        bus.network_done   = 1'b0;
        bus.detected_digit = 4'h0;
        bus.cost_ready     = 1'b0;
        bus.cost_output    = 8'h00;

        // Reset state.
        #12;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_tx_data", bus.tx_data, 8'hFF);
        check_eq("rst_tx_load", bus.tx_load, 0);
        check_eq("rst_tx_shift", bus.tx_shift, 0);
        check_eq("rst_cost_req", bus.cost_req, 0);
        tick();
        n_rst = 1'b1;
        repeat (4) tick();
        check_eq("post_rst_loads", load_cnt, 0);
        check_eq("post_rst_creq", creq_cnt, 0);

        // Digit read with nothing detected yet.
        read_digit();

        // Digit 7 detected, read once, then dig_valid is cleared.
        pulse_done(4'h7);
        read_digit();
        read_status();
        read_digit();

        // Cost answered after ~10 cycles.
        c0 = creq_cnt;
        l0 = load_cnt;
        sb.push_back(8'h5A);
        send_cmd(8'h01);
        repeat (9) tick();
        check_eq("busy_waiting", bus.busy, 1);
        pulse_cost(8'h5A);
        wait_load(l0);
        do_shift(8);
        check_eq("cost_req_pulses", creq_cnt - c0, 1);
        read_status();
        read_status();

        // Cost engine never answers: timeout code after COST_TIMEOUT cycles.
        c0 = creq_cnt;
        l0 = load_cnt;
        sb.push_back(8'hFE);
        send_cmd(8'h01);
        wait_load(l0);
        check_eq("timeout_latency", load_cyc - creq_cyc - 1, TIMEOUT);
        check_eq("timeout_creq", creq_cnt - c0, 1);
        do_shift(8);
        check_eq("timeout_busy", bus.busy, 0);

        // Slave select abort after 3 edges, then a normal status read.
        pulse_done(4'h3);
        l0 = load_cnt;
        s0 = shift_cnt;
        sb.push_back({5'b00000, m_dv, 1'b0, m_cs});
        m_cs = 1'b0;
        send_cmd(8'h03);
        wait_load(l0);
        do_shift(3);
        bus.ss_n = 1'b1;
        tick();
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_shifts", shift_cnt - s0, 3);
        tick();
        read_status();

        // New digit arriving during LOAD of a digit read.
        l0 = load_cnt;
        sb.push_back({4'h0, m_digit});
        send_cmd(8'h02);
        tick();
        bus.network_done   = 1'b1;
        bus.detected_digit = 4'h9;
        tick();
        bus.network_done = 1'b0;
        m_dv    = 1'b1;
        m_digit = 4'h9;
        wait_load(l0);
        do_shift(8);
        read_digit();
        read_digit();

        // Unknown command: no response.
        l0 = load_cnt;
        send_cmd(8'h55);
        repeat (3) tick();
        check_eq("unknown_no_load", load_cnt - l0, 0);
        check_eq("unknown_busy", bus.busy, 0);

        // rx_valid while shifting is ignored.
        c0 = creq_cnt;
        l0 = load_cnt;
        sb.push_back(m_dv ? {4'h0, m_digit} : 8'hFF);
        m_dv = 1'b0;
        send_cmd(8'h02);
        wait_load(l0);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h01;
        tick();
        bus.rx_valid = 1'b0;
        do_shift(8);
        check_eq("ignored_rx_creq", creq_cnt - c0, 0);
        check_eq("ignored_rx_busy", bus.busy, 0);

        // cost_ready while idle only sets cost_seen.
        l0 = load_cnt;
        pulse_cost(8'h33);
        check_eq("idle_cost_no_load", load_cnt - l0, 0);
        read_status();

        // Reset in the middle of a cost wait.
        pulse_done(4'h5);
        pulse_cost(8'h11);
        l0 = load_cnt;
        send_cmd(8'h01);
        repeat (5) tick();
        n_rst = 1'b0;
        #1;
        check_eq("midrst_busy", bus.busy, 0);
        check_eq("midrst_tx_data", bus.tx_data, 8'hFF);
        tick();
        n_rst = 1'b1;
        m_dv = 1'b0;
        m_cs = 1'b0;
        repeat (5) tick();
        check_eq("midrst_no_load", load_cnt - l0, 0);
        read_status();
        read_digit();

        check_eq("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
